// File: rtl/sid_pkg.sv
// Shared constants and types for the voice bank register bus.
package sid_pkg;

  localparam int SID_ADDR_W = 5;
  localparam int SID_DATA_W = 8;
  localparam int SID_WR_W   = SID_ADDR_W + SID_DATA_W;

  // Highest writable register; anything above is discarded.
  localparam logic [SID_ADDR_W-1:0] SID_LAST_REG    = 5'h18;

  localparam logic [SID_ADDR_W-1:0] SID_VOICE1_BASE = 5'h00;
  localparam logic [SID_ADDR_W-1:0] SID_VOICE2_BASE = 5'h07;
  localparam logic [SID_ADDR_W-1:0] SID_VOICE3_BASE = 5'h0E;

  // Per-voice register offsets from the voice base.
  typedef enum logic [2:0] {
    FREQ_LO = 3'd0,
    FREQ_HI = 3'd1,
    PW_LO   = 3'd2,
    PW_HI   = 3'd3,
    CTRL    = 3'd4
  } sid_voice_reg_e;

  // One queued register write.
  typedef struct packed {
    logic [SID_ADDR_W-1:0] addr;
    logic [SID_DATA_W-1:0] data;
  } sid_wr_t;

  // True when the address maps onto a real register.
  function automatic logic sid_writable(input logic [SID_ADDR_W-1:0] addr);
    return (addr <= SID_LAST_REG);
  endfunction

endpackage

// File: rtl/sid_wr_fifo.sv
// Show-ahead synchronous FIFO of {addr, data} writes for the host port.
module sid_wr_fifo
  import sid_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push,
  input  logic    pop,
  input  sid_wr_t wdata,
  output sid_wr_t rdata,
  output logic    full,
  output logic    empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = 1;

  logic [PTR_W:0] wr_ptr_r;
  logic [PTR_W:0] rd_ptr_r;
  sid_wr_t        mem_r [DEPTH];
  logic           do_push_s;
  logic           do_pop_s;

  // Extra pointer bit distinguishes full from empty when indices match.
  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign full      = (wr_ptr_r[PTR_W] != rd_ptr_r[PTR_W]) &&
                     (wr_ptr_r[PTR_W-1:0] == rd_ptr_r[PTR_W-1:0]);
  assign do_pop_s  = pop && !empty;
  // A pop frees the slot being written, so push-while-full is legal with a pop.
  assign do_push_s = push && (!full || do_pop_s);
  assign rdata     = mem_r[rd_ptr_r[PTR_W-1:0]];

  // Storage and pointer update; reset flushes all entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r[PTR_W-1:0]] <= wdata;
        wr_ptr_r                   <= wr_ptr_r + PTR_ONE;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/sid_reg_sched.sv
// Voice bank register bus scheduler: tick divider, two-port round-robin
// arbiter, address filter and registered bus outputs.
module sid_reg_sched
  import sid_pkg::*;
#(
  parameter int CLK_DIV    = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  iRstN,
  input  logic                  iAValid,
  input  logic [SID_ADDR_W-1:0] iAAddr,
  input  logic [SID_DATA_W-1:0] iAData,
  output logic                  oAReady,
  input  logic                  iBValid,
  input  logic [SID_ADDR_W-1:0] iBAddr,
  input  logic [SID_DATA_W-1:0] iBData,
  output logic                  oBReady,
  output logic                  oClkEn,
  output logic                  oWE,
  output logic [SID_ADDR_W-1:0] oAddr,
  output logic [SID_DATA_W-1:0] oData,
  output logic                  oDrop,
  output logic [7:0]            oDropCnt
);

  localparam int              CNT_W    = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = 1;

  logic [CNT_W-1:0]      cnt_r;
  logic                  clk_en_r;
  logic                  rr_last_b_r;
  logic                  we_r;
  logic                  drop_r;
  logic [SID_ADDR_W-1:0] addr_r;
  logic [SID_DATA_W-1:0] data_r;
  logic [7:0]            drop_cnt_r;

  logic                  fifo_full_s;
  logic                  fifo_empty_s;
  sid_wr_t               fifo_rdata_s;
  sid_wr_t               a_wr_s;
  logic                  slot_s;
  logic                  grant_a_s;
  logic                  grant_b_s;
  sid_wr_t               sel_s;

  assign a_wr_s  = '{addr: iAAddr, data: iAData};
  assign oAReady = !fifo_full_s;
  assign oBReady = grant_b_s;

  sid_wr_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (iRstN),
    .push  (iAValid && !fifo_full_s),
    .pop   (grant_a_s),
    .wdata (a_wr_s),
    .rdata (fifo_rdata_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // Tick divider; the tick pulse appears in the cycle after the last count.
  always_ff @(posedge clk or negedge iRstN) begin
    if (!iRstN) begin
      cnt_r    <= '0;
      clk_en_r <= 1'b0;
    end else begin
      clk_en_r <= (cnt_r == CNT_LAST);
      if (cnt_r == CNT_LAST) begin
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + CNT_ONE;
      end
    end
  end

  // Slot availability and round-robin grant between host FIFO and playback port.
  always_comb begin
    slot_s    = (cnt_r != CNT_LAST);
    grant_a_s = 1'b0;
    grant_b_s = 1'b0;
    if (slot_s) begin
      case ({!fifo_empty_s, iBValid})
        2'b10:   grant_a_s = 1'b1;
        2'b01:   grant_b_s = 1'b1;
        2'b11: begin
          if (rr_last_b_r) begin
            grant_a_s = 1'b1;
          end else begin
            grant_b_s = 1'b1;
          end
        end
        default: begin
          grant_a_s = 1'b0;
          grant_b_s = 1'b0;
        end
      endcase
    end else begin
      grant_a_s = 1'b0;
      grant_b_s = 1'b0;
    end
    if (grant_a_s) begin
      sel_s = fifo_rdata_s;
    end else begin
      sel_s = '{addr: iBAddr, data: iBData};
    end
  end

  // Output stage: write strobe or drop pulse, RR pointer and drop counter.
  always_ff @(posedge clk or negedge iRstN) begin
    if (!iRstN) begin
      rr_last_b_r <= 1'b1;
      we_r        <= 1'b0;
      drop_r      <= 1'b0;
      addr_r      <= '0;
      data_r      <= '0;
      drop_cnt_r  <= 8'h00;
    end else begin
      we_r   <= 1'b0;
      drop_r <= 1'b0;
      if (grant_a_s || grant_b_s) begin
        rr_last_b_r <= grant_b_s;
        if (sid_writable(sel_s.addr)) begin
          we_r   <= 1'b1;
          addr_r <= sel_s.addr;
          data_r <= sel_s.data;
        end else begin
          drop_r <= 1'b1;
          if (drop_cnt_r != 8'hFF) begin
            drop_cnt_r <= drop_cnt_r + 8'h01;
          end
        end
      end
    end
  end

  assign oClkEn   = clk_en_r;
  assign oWE      = we_r;
  assign oAddr    = addr_r;
  assign oData    = data_r;
  assign oDrop    = drop_r;
  assign oDropCnt = drop_cnt_r;

endmodule

// File: tb/tb_sid_reg_sched.sv
// Self-checking bench for sid_reg_sched: directed table, corner sequences and
// randomized traffic checked against a queue-based reference model.
module tb_sid_reg_sched;

  localparam int CLK_DIV    = 12;
  localparam int FIFO_DEPTH = 4;

  logic       clk = 1'b0;
  logic       iRstN;
  logic       iAValid, iBValid;
  logic [4:0] iAAddr, iBAddr;
  logic [7:0] iAData, iBData;
  logic       oAReady, oBReady, oClkEn, oWE, oDrop;
  logic [4:0] oAddr;
  logic [7:0] oData, oDropCnt;

  always #5 clk = ~clk;

  sid_reg_sched #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .iRstN(iRstN),
    .iAValid(iAValid), .iAAddr(iAAddr), .iAData(iAData), .oAReady(oAReady),
    .iBValid(iBValid), .iBAddr(iBAddr), .iBData(iBData), .oBReady(oBReady),
    .oClkEn(oClkEn), .oWE(oWE), .oAddr(oAddr), .oData(oData),
    .oDrop(oDrop), .oDropCnt(oDropCnt)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state: cycle number since reset release, host queue,
  // who was served last, and the expected registered bus outputs.
  logic [12:0] m_q[$];
  int          t;
  bit          m_last_b;
  logic        m_clken, m_we, m_drop;
  logic [4:0]  m_addr;
  logic [7:0]  m_data, m_dcnt;
  bit          m_gb;
  logic        s_aready, s_bready;

  typedef struct {
    logic av; logic [4:0] aa; logic [7:0] ad;
    logic bv; logic [4:0] ba; logic [7:0] bd;
    logic exp_br; logic exp_we; logic exp_drop;
    logic [4:0] exp_addr; logic [7:0] exp_data; logic [7:0] exp_dcnt;
  } vec_t;
  vec_t tbl[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, t);
    end
  endtask

  function automatic logic [23:0] dut_out();
    return {oClkEn, oWE, oDrop, oAddr, oData, oDropCnt};
  endfunction

  task automatic model_reset();
    m_q.delete();
    t = 0; m_last_b = 1'b1;
    m_clken = 1'b0; m_we = 1'b0; m_drop = 1'b0;
    m_addr = 5'h00; m_data = 8'h00; m_dcnt = 8'h00; m_gb = 1'b0;
  endtask

  // One clock cycle: drive inputs, check handshakes, predict and check outputs.
  task automatic step(input logic av, input logic [4:0] aa, input logic [7:0] ad,
                      input logic bv, input logic [4:0] ba, input logic [7:0] bd);
    bit slot, ga, gb, ar;
    logic [12:0] e;
    iAValid = av; iAAddr = aa; iAData = ad;
    iBValid = bv; iBAddr = ba; iBData = bd;
    #1;
    slot = (t % CLK_DIV) != (CLK_DIV - 1);
    ar   = m_q.size() < FIFO_DEPTH;
    ga = 1'b0; gb = 1'b0;
    if (slot) begin
      if (m_q.size() > 0 && (!bv || m_last_b)) ga = 1'b1;
      else if (bv) gb = 1'b1;
    end
    s_aready = oAReady; s_bready = oBReady;
    check("a_ready", {31'd0, oAReady}, {31'd0, ar});
    check("b_ready", {31'd0, oBReady}, {31'd0, gb});
    e = 13'h0000;
    if (ga) e = m_q.pop_front();
    else if (gb) e = {ba, bd};
    if (av && ar) m_q.push_back({aa, ad});
    m_we = 1'b0; m_drop = 1'b0;
    if (ga || gb) begin
      m_last_b = gb;
      if (e[12:8] <= 5'h18) begin
        m_we = 1'b1; m_addr = e[12:8]; m_data = e[7:0];
      end else begin
        m_drop = 1'b1;
        if (m_dcnt != 8'hFF) m_dcnt = m_dcnt + 8'h01;
      end
    end
    m_clken = ((t + 1) % CLK_DIV) == 0;
    m_gb = gb;
    @(posedge clk); #1;
    t++;
    check("outputs", {8'd0, dut_out()}, {8'd0, m_clken, m_we, m_drop, m_addr, m_data, m_dcnt});
  endtask

  task automatic idle();
    step(1'b0, 5'h00, 8'h00, 1'b0, 5'h00, 8'h00);
  endtask

  initial begin
    logic       bv;
    logic [4:0] ba;
    logic [7:0] bd;
    int         saw_full;
    int         guard;

    tbl[0] = '{1'b1, 5'h04, 8'h41, 1'b0, 5'h00, 8'h00, 1'b0, 1'b0, 1'b0, 5'h00, 8'h00, 8'h00};
    tbl[1] = '{1'b0, 5'h00, 8'h00, 1'b0, 5'h00, 8'h00, 1'b0, 1'b1, 1'b0, 5'h04, 8'h41, 8'h00};
    tbl[2] = '{1'b0, 5'h00, 8'h00, 1'b0, 5'h00, 8'h00, 1'b0, 1'b0, 1'b0, 5'h04, 8'h41, 8'h00};
    tbl[3] = '{1'b0, 5'h00, 8'h00, 1'b1, 5'h1B, 8'h55, 1'b1, 1'b0, 1'b1, 5'h04, 8'h41, 8'h01};
    tbl[4] = '{1'b0, 5'h00, 8'h00, 1'b0, 5'h00, 8'h00, 1'b0, 1'b0, 1'b0, 5'h04, 8'h41, 8'h01};
    tbl[5] = '{1'b0, 5'h00, 8'h00, 1'b1, 5'h10, 8'h99, 1'b1, 1'b1, 1'b0, 5'h10, 8'h99, 8'h01};

    iRstN = 1'b0;
    iAValid = 1'b0; iAAddr = 5'h00; iAData = 8'h00;
    iBValid = 1'b0; iBAddr = 5'h00; iBData = 8'h00;
    model_reset();
    #12;
    check("reset_hold", {7'd0, dut_out(), oAReady}, {7'd0, 24'h000000, 1'b1});
    @(posedge clk); #1;
    iRstN = 1'b1;
    #1;
    check("reset_state", {7'd0, dut_out(), oAReady}, {7'd0, 24'h000000, 1'b1});

    // Directed table: single host write, a dropped and a valid playback write.
    for (int i = 0; i < 6; i++) begin
      step(tbl[i].av, tbl[i].aa, tbl[i].ad, tbl[i].bv, tbl[i].ba, tbl[i].bd);
      check("tbl_bready", {31'd0, s_bready}, {31'd0, tbl[i].exp_br});
      check("tbl_out", {13'd0, oWE, oDrop, oAddr, oData, oDropCnt},
            {13'd0, tbl[i].exp_we, tbl[i].exp_drop, tbl[i].exp_addr, tbl[i].exp_data, tbl[i].exp_dcnt});
      check("tbl_no_tick", {31'd0, oClkEn}, 32'd0);
    end

    // Idle ticks land on cycles 12, 24, 36.
    while (t < 36) begin
      idle();
      if (t == 12 || t == 24 || t == 36) check("tick_pulse", {31'd0, oClkEn}, 32'd1);
    end

    // Request in the last-count cycle issues after the tick.
    while ((t % CLK_DIV) != (CLK_DIV - 1)) idle();
    step(1'b1, 5'h05, 8'h77, 1'b0, 5'h00, 8'h00);
    check("tick_no_we", {30'd0, oClkEn, oWE}, 32'd2);
    idle();
    check("after_tick_we", {18'd0, oWE, oAddr, oData}, {18'd0, 1'b1, 5'h05, 8'h77});

    // Host floods the FIFO while playback holds a request: alternating grants.
    saw_full = 0;
    bd = 8'hB0;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 5'(i % 24), 8'(8'hA0 + i), 1'b1, 5'h0E, bd);
      if (!s_aready) saw_full++;
      if (m_gb) bd = bd + 8'h01;
    end
    check("fifo_full_seen", {31'd0, saw_full > 0}, 32'd1);
    while (m_q.size() > 0) idle();

    // Randomized traffic; playback request held until accepted.
    bv = 1'b0; ba = 5'h00; bd = 8'h00;
    for (int i = 0; i < 600; i++) begin
      if (!bv && $urandom_range(0, 2) == 0) begin
        bv = 1'b1; ba = 5'($urandom_range(0, 31)); bd = 8'($urandom);
      end
      step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 8'($urandom), bv, ba, bd);
      if (m_gb) bv = 1'b0;
    end

    // Many dropped writes saturate the counter.
    for (int i = 0; i < 330; i++) step(1'b0, 5'h00, 8'h00, 1'b1, 5'h1B, 8'h12);
    check("drop_saturate", {24'd0, oDropCnt}, 32'h0000_00FF);

    // Asynchronous reset with entries queued in the FIFO.
    guard = 0;
    while (m_q.size() < 3 && guard < 20) begin
      step(1'b1, 5'h02, 8'(8'h30 + guard), 1'b1, 5'h03, 8'h33);
      guard++;
    end
    check("fifo_loaded", {31'd0, m_q.size() >= 3}, 32'd1);
    iAValid = 1'b0; iBValid = 1'b0;
    #2;
    iRstN = 1'b0;
    #1;
    check("async_reset", {7'd0, dut_out(), oAReady}, {7'd0, 24'h000000, 1'b1});
    repeat (2) @(posedge clk);
    #1;
    check("reset_held", {7'd0, dut_out(), oAReady}, {7'd0, 24'h000000, 1'b1});
    @(posedge clk); #1;
    iRstN = 1'b1;
    model_reset();
    for (int i = 0; i < 15; i++) begin
      idle();
      check("no_stale_we", {31'd0, oWE}, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
